// File: rtl/peripheral_dbg_pu_msp430_uart_host_pkg.sv
// Shared types and constants for the MSP430 debug-UART host.
// Command byte layout, sync character and frame length live here.
package peripheral_dbg_pu_msp430_uart_host_pkg;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        SEND_CMD,
        WDATA_LO,
        WDATA_HI,
        RDATA_LO,
        RDATA_HI,
        DONE
    } uart_host_state_t;

    localparam int          CMD_WR       = 7;
    localparam int          CMD_BW       = 6;
    localparam int          CMD_ADDR_MSB = 5;
    localparam int          CMD_ADDR_LSB = 0;
    localparam logic [7:0]  SYNC_CHAR    = 8'h80;
    localparam int          FRAME_BITS   = 10;

    function automatic logic [7:0] make_cmd(input logic wr, input logic bw, input logic [5:0] addr);
        logic [7:0] c;
        c                            = '0;
        c[CMD_WR]                    = wr;
        c[CMD_BW]                    = bw;
        c[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
        return c;
    endfunction

endpackage

// File: rtl/peripheral_dbg_pu_msp430_uart_host_rx.sv
// Receive path of the debug-UART host: 2-flop synchroniser, 3-sample majority filter,
// start detection and mid-bit sampling. start_o exists only with DBG_UART_HOST_TIMEOUT_EN.
module peripheral_dbg_pu_msp430_uart_host_rx
    import peripheral_dbg_pu_msp430_uart_host_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       dbg_clk,
    input  logic       dbg_rst,
    input  logic       en_i,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
`ifdef DBG_UART_HOST_TIMEOUT_EN
    ,
    output logic       start_o
`endif
);
    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    logic [1:0]  sync_q;
    logic [2:0]  hist_q;
    logic        filt_q;
    logic        busy_q;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic [7:0]  shift_q;
    logic        valid_q;
    logic        err_q;
    logic        filt;
    logic        fall;

    assign filt = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    assign fall = filt_q & ~filt;

    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            sync_q  <= '1;
            hist_q  <= '1;
            filt_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd_i};
            hist_q  <= {hist_q[1:0], sync_q[1]};
            filt_q  <= filt;
            valid_q <= 1'b0;
            if (!en_i) begin
                busy_q <= 1'b0;
            end else if (!busy_q) begin
                if (fall) begin
                    busy_q <= 1'b1;
                    cnt_q  <= HALF_LAST;
                    bit_q  <= '0;
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 16'd1;
            end else begin
                cnt_q <= BIT_LAST;
                // Start bit that has gone high again by mid-bit was a glitch.
                if (bit_q == '0) begin
                    busy_q <= ~filt;
                    bit_q  <= 4'd1;
                end else if (bit_q == 4'(FRAME_BITS - 1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    err_q   <= ~filt;
                end else begin
                    shift_q <= {filt, shift_q[7:1]};
                    bit_q   <= bit_q + 4'd1;
                end
            end
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;
`ifdef DBG_UART_HOST_TIMEOUT_EN
    assign start_o      = en_i & ~busy_q & fall;
`endif

endmodule

// File: rtl/peripheral_dbg_pu_msp430_uart_host.sv
// Host end of the MSP430 debug-UART link: serialises debug requests and collects read replies.
// Defining DBG_UART_HOST_TIMEOUT_EN adds a read-response timeout of TIMEOUT_CYCLES.
module peripheral_dbg_pu_msp430_uart_host
    import peripheral_dbg_pu_msp430_uart_host_pkg::*;
#(
    parameter int BAUD_DIV       = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        dbg_clk,
    input  logic        dbg_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_bw,
    input  logic [5:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sync_done,
    output logic        dbg_uart_txd,
    input  logic        dbg_uart_rxd
);
    localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

    uart_host_state_t state_q;
    logic        sent_q, tx_load_q;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        wr_q, bw_q, err_q;
    logic [5:0]  addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  rdata_lo_q;
    logic        req_ready_q, rsp_valid_q, rsp_err_q, sync_done_q;
    logic [15:0] rsp_rdata_q;
    logic        tx_busy_q, tx_done_q, txd_q;
    logic [8:0]  tx_shift_q;
    logic [15:0] tx_baud_q, tx_gap_q;
    logic [3:0]  tx_bits_q;
    logic        tx_idle, tx_state, rx_state, frame_sent, timeout;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_err;

    // The gap counter keeps the line high for a full bit time between frames.
    assign tx_idle    = ~tx_busy_q & (tx_gap_q == '0) & ~tx_load_q;
    assign tx_state   = state_q inside {SYNC, SEND_CMD, WDATA_LO, WDATA_HI};
    assign rx_state   = state_q inside {RDATA_LO, RDATA_HI};
    assign frame_sent = sent_q & tx_done_q;

    always_comb begin
        tx_byte_d = SYNC_CHAR;
        case (state_q)
            SEND_CMD: tx_byte_d = make_cmd(wr_q, bw_q, addr_q);
            WDATA_LO: tx_byte_d = wdata_q[7:0];
            WDATA_HI: tx_byte_d = bw_q ? wdata_q[7:0] : wdata_q[15:8];
            default:  tx_byte_d = SYNC_CHAR;
        endcase
    end

    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bits_q  <= '0;
            tx_gap_q   <= '0;
            tx_done_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_done_q <= 1'b0;
            if (tx_load_q) begin
                tx_busy_q  <= 1'b1;
                tx_shift_q <= {1'b1, tx_byte_q};
                txd_q      <= 1'b0;
                tx_baud_q  <= BIT_LAST;
                tx_bits_q  <= 4'(FRAME_BITS - 1);
            end else if (tx_busy_q) begin
                if (tx_baud_q == '0) begin
                    tx_baud_q <= BIT_LAST;
                    if (tx_bits_q == '0) begin
                        tx_busy_q <= 1'b0;
                        tx_done_q <= 1'b1;
                        tx_gap_q  <= BIT_LAST;
                        txd_q     <= 1'b1;
                    end else begin
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                        tx_bits_q  <= tx_bits_q - 4'd1;
                    end
                end else begin
                    tx_baud_q <= tx_baud_q - 16'd1;
                end
            end else if (tx_gap_q != '0) begin
                tx_gap_q <= tx_gap_q - 16'd1;
            end
        end
    end

    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            state_q     <= SYNC;
            sent_q      <= 1'b0;
            tx_load_q   <= 1'b0;
            tx_byte_q   <= SYNC_CHAR;
            wr_q        <= 1'b0;
            bw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_lo_q  <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            sync_done_q <= 1'b0;
        end else begin
            tx_load_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            if (tx_state && !sent_q && tx_idle) begin
                tx_byte_q <= tx_byte_d;
                tx_load_q <= 1'b1;
                sent_q    <= 1'b1;
            end
            case (state_q)
                SYNC: if (frame_sent) begin
                    sent_q      <= 1'b0;
                    sync_done_q <= 1'b1;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                IDLE: if (req_valid) begin
                    wr_q        <= req_wr;
                    bw_q        <= req_bw;
                    addr_q      <= req_addr;
                    wdata_q     <= req_wdata;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b0;
                    state_q     <= SEND_CMD;
                end
                SEND_CMD: if (frame_sent) begin
                    sent_q  <= 1'b0;
                    state_q <= wr_q ? (bw_q ? WDATA_HI : WDATA_LO) : (bw_q ? RDATA_HI : RDATA_LO);
                end
                WDATA_LO: if (frame_sent) begin
                    sent_q  <= 1'b0;
                    state_q <= WDATA_HI;
                end
                WDATA_HI: if (frame_sent) begin
                    sent_q      <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    state_q     <= DONE;
                end
                RDATA_LO: if (rx_valid) begin
                    rdata_lo_q <= rx_byte;
                    err_q      <= err_q | rx_err;
                    state_q    <= RDATA_HI;
                end else if (timeout) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= DONE;
                end
                RDATA_HI: if (rx_valid) begin
                    rsp_rdata_q <= bw_q ? {8'h00, rx_byte} : {rx_byte, rdata_lo_q};
                    rsp_err_q   <= err_q | rx_err;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else if (timeout) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= SYNC;
            endcase
        end
    end

`ifdef DBG_UART_HOST_TIMEOUT_EN
    logic        rx_start;
    logic [31:0] to_cnt_q;

    // Restarts on every received start bit so only a silent target times out.
    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            to_cnt_q <= '0;
        end else if (!rx_state || rx_start) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end

    assign timeout = rx_state & (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    peripheral_dbg_pu_msp430_uart_host_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .dbg_clk      (dbg_clk),
        .dbg_rst      (dbg_rst),
        .en_i         (rx_state),
        .rxd_i        (dbg_uart_rxd),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
`ifdef DBG_UART_HOST_TIMEOUT_EN
        ,
        .start_o      (rx_start)
`endif
    );

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign sync_done    = sync_done_q;
    assign dbg_uart_txd = txd_q;

endmodule

// File: tb/tb_peripheral_dbg_pu_msp430_uart_host.sv
// Bench for the debug-UART host: a target model decodes the serial stream and replies to reads,
// a scoreboard checks every response. Honours DBG_UART_HOST_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_peripheral_dbg_pu_msp430_uart_host;
    localparam int B = 4;
`ifdef DBG_UART_HOST_TIMEOUT_EN
    localparam int TO = 200;
`else
    localparam int TO = 65535;
`endif

    logic        dbg_clk = 1'b0;
    logic        dbg_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_bw = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        dbg_uart_rxd = 1'b1;
    logic        req_ready, rsp_valid, rsp_err, sync_done, dbg_uart_txd;
    logic [15:0] rsp_rdata;

    always #5 dbg_clk = ~dbg_clk;

    peripheral_dbg_pu_msp430_uart_host #(
        .BAUD_DIV       (B),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .dbg_clk      (dbg_clk),
        .dbg_rst      (dbg_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_bw       (req_bw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .sync_done    (sync_done),
        .dbg_uart_txd (dbg_uart_txd),
        .dbg_uart_rxd (dbg_uart_rxd)
    );

    typedef struct { logic [7:0] b; int n_reply; } tx_exp_t;
    typedef struct { logic [7:0] b; bit bad_stop; } rx_byte_t;
    typedef struct { logic [15:0] rdata; bit err; bit chk_rdata; } rsp_exp_t;

    tx_exp_t  exp_tx_q[$];
    rx_byte_t reply_q[$];
    int       reply_cnt_q[$];
    rsp_exp_t exp_rsp_q[$];

    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_rdata = '0;
    bit          model_known = 1'b1;
    bit          rst_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(posedge dbg_rst) rst_seen = 1'b1;

    // Scoreboard monitor: one expected response per rsp_valid pulse.
    always @(negedge dbg_clk) begin : rsp_monitor
        rsp_exp_t e;
        if (!dbg_rst && rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid rdata=%h err=%0d expected none", rsp_rdata, rsp_err);
            end else begin
                e = exp_rsp_q.pop_front();
                if (e.chk_rdata) check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                $display("rsp: rdata=%h err=%0d", rsp_rdata, rsp_err);
            end
        end
    end

    // Target model, receive side: decode each frame on txd and compare to the expected stream.
    initial begin : tx_decoder
        logic [7:0] b;
        logic       stop_bit;
        tx_exp_t    e;
        forever begin
            @(negedge dbg_clk);
            if (!dbg_rst && dbg_uart_txd == 1'b0) begin
                rst_seen = 1'b0;
                repeat (B / 2) @(negedge dbg_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge dbg_clk);
                    b[i] = dbg_uart_txd;
                end
                repeat (B) @(negedge dbg_clk);
                stop_bit = dbg_uart_txd;
                if (!rst_seen) begin
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx_byte: got %h expected none", b);
                    end else begin
                        e = exp_tx_q.pop_front();
                        check("tx_byte", 32'(b), 32'(e.b));
                        check("tx_stop", 32'(stop_bit), 32'd1);
                        $display("txd byte: %h", b);
                        if (e.n_reply > 0) reply_cnt_q.push_back(e.n_reply);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad);
        dbg_uart_rxd = 1'b0;
        repeat (B) @(negedge dbg_clk);
        for (int i = 0; i < 8; i++) begin
            dbg_uart_rxd = b[i];
            repeat (B) @(negedge dbg_clk);
        end
        dbg_uart_rxd = ~bad;
        repeat (B) @(negedge dbg_clk);
        dbg_uart_rxd = 1'b1;
        repeat (B) @(negedge dbg_clk);
    endtask

    // Target model, reply side.
    initial begin : responder
        int       n;
        rx_byte_t r;
        forever begin
            @(negedge dbg_clk);
            if (reply_cnt_q.size() != 0) begin
                n = reply_cnt_q.pop_front();
                repeat (2 * B + int'($urandom_range(0, 5))) @(negedge dbg_clk);
                for (int k = 0; k < n; k++) begin
                    r = reply_q.pop_front();
                    send_byte(r.b, r.bad_stop);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 3000) begin
            @(negedge dbg_clk);
            n++;
        end
        if (req_ready !== 1'b1) check(name, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_tx_q.size() != 0 || exp_rsp_q.size() != 0 || reply_q.size() != 0 ||
                req_ready !== 1'b1) && n < 5000) begin
            @(negedge dbg_clk);
            n++;
        end
        check(name, 32'(exp_tx_q.size() + exp_rsp_q.size() + reply_q.size()), 32'd0);
    endtask

    // Reference model: byte stream and response derived from the request fields.
    task automatic do_req(input bit wr, input bit bw, input logic [5:0] addr, input logic [15:0] wd,
                          input logic [15:0] rd, input bit bad, input bit noreply);
        logic [7:0]  cmd;
        logic [15:0] exp_rd;
        int          nrep;
        cmd  = {wr, bw, addr};
        nrep = (wr || noreply) ? 0 : (bw ? 1 : 2);
        exp_tx_q.push_back('{cmd, nrep});
        if (wr) begin
            exp_tx_q.push_back('{wd[7:0], 0});
            if (!bw) exp_tx_q.push_back('{wd[15:8], 0});
            exp_rsp_q.push_back('{model_rdata, 1'b0, model_known});
        end else if (!noreply) begin
            if (bw) begin
                reply_q.push_back('{rd[7:0], bad});
                exp_rd = {8'h00, rd[7:0]};
            end else begin
                reply_q.push_back('{rd[7:0], 1'b0});
                reply_q.push_back('{rd[15:8], bad});
                exp_rd = rd;
            end
            exp_rsp_q.push_back('{exp_rd, bad, !bad});
            if (bad) model_known = 1'b0;
            else begin
                model_rdata = exp_rd;
                model_known = 1'b1;
            end
        end else begin
`ifdef DBG_UART_HOST_TIMEOUT_EN
            exp_rsp_q.push_back('{model_rdata, 1'b1, model_known});
`endif
        end
        wait_ready("req_ready_timeout");
        $display("req: wr=%0d bw=%0d addr=%h wdata=%h", wr, bw, addr, wd);
        req_wr    = wr;
        req_bw    = bw;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge dbg_clk);
        check("req_ready_after_accept", 32'(req_ready), 32'd0);
        // Junk while busy must be ignored.
        for (int j = 0; j < 3; j++) begin
            req_wr    = 1'($urandom);
            req_bw    = 1'($urandom);
            req_addr  = 6'($urandom);
            req_wdata = 16'($urandom);
            @(negedge dbg_clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_sync_done", 32'(sync_done), 32'd0);
        check("rst_txd", 32'(dbg_uart_txd), 32'd1);
    endtask

    task automatic do_reset(input int hold);
        dbg_rst = 1'b1;
        exp_tx_q.delete();
        exp_rsp_q.delete();
        reply_q.delete();
        reply_cnt_q.delete();
        model_rdata = '0;
        model_known = 1'b1;
        exp_tx_q.push_back('{8'h80, 0});
        repeat (hold) @(negedge dbg_clk);
        check_reset_values();
        dbg_rst = 1'b0;
        begin
            int n = 0;
            while (sync_done !== 1'b1 && n < 200) begin
                @(negedge dbg_clk);
                n++;
            end
        end
        check("sync_done_after_reset", 32'(sync_done), 32'd1);
        check("req_ready_after_sync", 32'(req_ready), 32'd1);
        wait_idle("sync_stream_done");
    endtask

    initial begin : main
        int n;
        logic [15:0] rv;
        do_reset(4);

        do_req(1'b1, 1'b0, 6'h01, 16'hA5C3, 16'h0000, 1'b0, 1'b0);
        wait_idle("word_write_done");
        do_req(1'b0, 1'b0, 6'h00, 16'h0000, 16'h1234, 1'b0, 1'b0);
        wait_idle("word_read_done");
        do_req(1'b1, 1'b1, 6'h05, 16'h007E, 16'h0000, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 6'h02, 16'h0000, 16'hFF9F, 1'b0, 1'b0);
        wait_idle("byte_ops_done");

        // Random back-to-back traffic.
        for (int t = 0; t < 12; t++) begin
            rv = 16'($urandom);
            do_req(1'($urandom), 1'($urandom), 6'($urandom), 16'($urandom), rv, 1'b0, 1'b0);
        end
        wait_idle("random_traffic_done");

        do_req(1'b0, 1'b0, 6'h03, 16'h0000, 16'($urandom), 1'b1, 1'b0);
        wait_idle("bad_stop_done");
        do_req(1'b1, 1'b0, 6'h04, 16'($urandom), 16'h0000, 1'b0, 1'b0);
        wait_idle("write_after_err_done");

        do_req(1'b0, 1'b0, 6'h07, 16'h0000, 16'h0000, 1'b0, 1'b1);
`ifdef DBG_UART_HOST_TIMEOUT_EN
        wait_idle("timeout_rsp_done");
`else
        repeat (1000) @(negedge dbg_clk);
        check("no_reply_still_busy", 32'(req_ready), 32'd0);
`endif

        do_reset(4);

        // Reset during the third data bit of a command byte (0xAA: bit 2 is 0).
        wait_ready("req_ready_before_abort");
        req_wr    = 1'b1;
        req_bw    = 1'b0;
        req_addr  = 6'h2A;
        req_wdata = 16'($urandom);
        req_valid = 1'b1;
        @(negedge dbg_clk);
        req_valid = 1'b0;
        n = 0;
        while (dbg_uart_txd !== 1'b0 && n < 100) begin
            @(negedge dbg_clk);
            n++;
        end
        check("abort_cmd_start", 32'(dbg_uart_txd), 32'd0);
        repeat (3 * B + 1) @(negedge dbg_clk);
        check("abort_txd_bit2", 32'(dbg_uart_txd), 32'd0);
        #2 dbg_rst = 1'b1;
        #1 check("txd_async_reset", 32'(dbg_uart_txd), 32'd1);
        do_reset(60);

        do_req(1'b1, 1'b0, 6'h11, 16'($urandom), 16'h0000, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 6'h12, 16'h0000, 16'($urandom), 1'b0, 1'b0);
        wait_idle("post_reset_traffic_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
